// File: rtl/nfp_fix2single_pkg.sv
// nfp_fix2single_pkg
//   Shared constants, the packed IEEE single layout and the pipeline stage
//   register layouts for the sfix32_En28 -> single converter.
//   No ports (package).
package nfp_fix2single_pkg;

  localparam int FIX_W    = 32;
  localparam int FRAC_LEN = 28;
  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;

  // Biased exponent when the magnitude MSB sits at bit FIX_W-1 (130).
  // Each leading zero lowers it by one.
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(FIX_W - 1 - FRAC_LEN + EXP_BIAS);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } single_t;

  // S1: sign / magnitude.
  typedef struct packed {
    logic             sign;
    logic [FIX_W-1:0] mag;
  } s1_t;

  // S2: normalized magnitude. The leading one is implicit after the shift,
  // so only the bits below it are kept.
  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [EXP_W-1:0] exp;
    logic [FIX_W-2:0] norm;
  } s2_t;

  // Two's complement magnitude. 0x80000000 stays 0x80000000, which reads
  // correctly as unsigned 2^31.
  function automatic logic [FIX_W-1:0] fix_abs(input logic [FIX_W-1:0] x);
    return x[FIX_W-1] ? (~x + FIX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/nfp_convert_sfix_32_en28_to_single_lzc32.sv
// nfp_lzc32
//   Combinational 32-bit leading-zero counter.
//   din      in  32  value to scan
//   lz_cnt   out  5  number of zeros above the most significant one (0 if din==0)
//   all_zero out  1  din == 0
module nfp_lzc32 (
  input  logic [31:0] din,
  output logic [4:0]  lz_cnt,
  output logic        all_zero
);

  logic found;

  always_comb begin
    lz_cnt   = '0;
    found    = 1'b0;
    all_zero = ~|din;
    for (int i = 31; i >= 0; i--) begin
      if (!found && din[i]) begin
        lz_cnt = 5'(31 - i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nfp_convert_sfix_32_en28_to_single.sv
// nfp_convert_sfix_32_en28_to_single
//   Three-stage pipelined converter from sfix32_En28 (two's complement,
//   28 fractional bits) to IEEE-754 single, round-to-nearest-even.
//   S1 sign/magnitude, S2 normalize (nfp_lzc32), S3 round/pack = output reg.
//   Valid/ready on both sides, one sample per cycle.
//
//   clk          in   1  clock
//   reset_n      in   1  synchronous active-low reset
//   in_data      in  32  sfix32_En28 sample
//   in_valid     in   1  in_data qualifier
//   in_ready     out  1  sample accepted this cycle when in_valid
//   out_data     out 32  {sign, exp[7:0], frac[22:0]}
//   out_valid    out  1  out_data qualifier
//   out_inexact  out  1  result was rounded (only with NFP_INEXACT_FLAG_EN)
//   out_ready    in   1  downstream accepts out_data
//
//   Build option: define NFP_INEXACT_FLAG_EN to add out_inexact.
module nfp_convert_sfix_32_en28_to_single (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
`ifdef NFP_INEXACT_FLAG_EN
  output logic        out_inexact,
`endif
  input  logic        out_ready
);

  import nfp_fix2single_pkg::*;

  logic    s1_valid_q, s1_valid_d;
  s1_t     s1_q, s1_d;
  logic    s2_valid_q, s2_valid_d;
  s2_t     s2_q, s2_d;
  logic    out_valid_q, out_valid_d;
  single_t out_data_q, out_data_d;
`ifdef NFP_INEXACT_FLAG_EN
  logic    out_inexact_q, out_inexact_d;
`endif

  logic s1_load, s2_load, s3_load;

  logic [4:0] lz_cnt;
  logic       mag_zero;

  logic [MANT_W-1:0] frac_trunc;
  logic              guard, sticky, round_up;
  logic [MANT_W:0]   frac_sum;
  logic [EXP_W-1:0]  exp_rnd;
  single_t           packed_res;

  nfp_lzc32 u_lzc (
    .din      (s1_q.mag),
    .lz_cnt   (lz_cnt),
    .all_zero (mag_zero)
  );

  // Handshake: a stage can take new data if it is empty or its contents move
  // on this cycle. in_ready depends only on state and out_ready.
  always_comb begin
    s3_load  = !out_valid_q | out_ready;
    s2_load  = !s2_valid_q | s3_load;
    s1_load  = !s1_valid_q | s2_load;
    in_ready = s1_load;
  end

  // Rounding of the S2 contents into the packed single.
  always_comb begin
    frac_trunc = s2_q.norm[FIX_W-2:FIX_W-1-MANT_W];
    guard      = s2_q.norm[FIX_W-2-MANT_W];
    sticky     = |s2_q.norm[FIX_W-3-MANT_W:0];
    round_up   = guard & (sticky | frac_trunc[0]);
    frac_sum   = {1'b0, frac_trunc} + {{MANT_W{1'b0}}, round_up};
    // A carry out of the fraction leaves frac_sum[22:0] == 0, so only the
    // exponent needs adjusting.
    exp_rnd    = s2_q.exp + {{(EXP_W-1){1'b0}}, frac_sum[MANT_W]};
    packed_res = '0;
    if (!s2_q.zero) begin
      packed_res.sign = s2_q.sign;
      packed_res.exp  = exp_rnd;
      packed_res.frac = frac_sum[MANT_W-1:0];
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    s2_valid_d  = s2_valid_q;
    s2_d        = s2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef NFP_INEXACT_FLAG_EN
    out_inexact_d = out_inexact_q;
`endif

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sign = in_data[FIX_W-1];
        s1_d.mag  = fix_abs(in_data);
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.sign = s1_q.sign;
        s2_d.zero = mag_zero;
        s2_d.exp  = EXP_TOP - {{(EXP_W-5){1'b0}}, lz_cnt};
        s2_d.norm = (FIX_W-1)'(s1_q.mag << lz_cnt);
      end
    end

    if (s3_load) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_data_d = packed_res;
`ifdef NFP_INEXACT_FLAG_EN
        out_inexact_d = guard | sticky;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef NFP_INEXACT_FLAG_EN
      out_inexact_q <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef NFP_INEXACT_FLAG_EN
      out_inexact_q <= out_inexact_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef NFP_INEXACT_FLAG_EN
  assign out_inexact = out_inexact_q;
`endif

endmodule

// File: tb/tb_nfp_convert_sfix_32_en28_to_single.sv
// tb_nfp_convert_sfix_32_en28_to_single
//   Scoreboard bench: the driver pushes the expected result of every
//   accepted sample; a negedge monitor compares whatever the DUT presents.
module tb_nfp_convert_sfix_32_en28_to_single;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef NFP_INEXACT_FLAG_EN
  logic        out_inexact;
`endif

  nfp_convert_sfix_32_en28_to_single dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef NFP_INEXACT_FLAG_EN
    .out_inexact (out_inexact),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        inex;
    int          acc_edge;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  bit   head_seen = 1'b0;
  bit   mon_en    = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the exact value x*2^-28 as a double, rounded to single RNE.
  function automatic logic [32:0] ref_conv(input logic [31:0] x);
    real         r;
    logic [63:0] b;
    logic [7:0]  e;
    logic [23:0] m;
    logic [28:0] rem;
    logic        rnd;
    if (x == 32'd0) return 33'd0;
    r   = $itor($signed(x)) / 268435456.0;
    b   = $realtobits(r);
    e   = 8'(b[62:52] - 11'd896);
    m   = {1'b0, b[51:29]};
    rem = b[28:0];
    rnd = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && m[0]);
    m   = m + 24'(rnd);
    if (m[23]) e = e + 8'd1;
    return {(rem != 29'd0), b[63], e, m[22:0]};
  endfunction

  // One cycle: drive after the edge, decide acceptance mid-cycle.
  task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                      input logic [31:0] e, input logic x, input bit chk,
                      output logic acc);
    exp_t it;
    @(posedge clk); #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    acc = v & in_ready;
    if (acc) begin
      it.data = e; it.inex = x; it.acc_edge = cyc + 1; it.chk_lat = chk;
      sb.push_back(it);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] e, input logic x, input bit chk);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(1'b1, d, 1'b1, e, x, chk, acc);
      tries++;
    end
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: input 0x%08h not accepted in 20 cycles", d);
    end
  endtask

  always @(negedge clk) begin
    exp_t h;
    if (mon_en && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_output: got out_data 0x%08h, expected no output", out_data);
      end else begin
        h = sb[0];
        if (!head_seen) begin
          head_seen = 1'b1;
          if (h.chk_lat) check("latency_edge", 32'(cyc), 32'(h.acc_edge + 2));
        end
        check("out_data", out_data, h.data);
`ifdef NFP_INEXACT_FLAG_EN
        check("out_inexact", {31'd0, out_inexact}, {31'd0, h.inex});
`endif
        if (out_ready) begin
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  logic [31:0] dir_in  [8] = '{32'h1000_0000, 32'hF000_0000, 32'h8000_0000, 32'h0000_0001,
                               32'h0000_0000, 32'h0100_0001, 32'h0100_0003, 32'h7FFF_FFFF};
  logic [31:0] dir_exp [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'hC100_0000, 32'h3180_0000,
                               32'h0000_0000, 32'h3D80_0000, 32'h3D80_0002, 32'h4100_0000};
  logic        dir_inx [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  logic [31:0] bp_in  [8] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000,
                              32'h5000_0000, 32'h6000_0000, 32'h7000_0000, 32'hE000_0000};
  logic [31:0] bp_exp [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                              32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'hC000_0000};

  initial begin
    logic        acc;
    logic [31:0] x;
    logic [32:0] r;
    int          idx, t, w;
    bit          first_low;

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef NFP_INEXACT_FLAG_EN
    check("reset_out_inexact", {31'd0, out_inexact}, 32'd0);
`endif
    mon_en = 1'b1;

    // Directed exact and rounding vectors, back to back, latency checked.
    for (int i = 0; i < 8; i++) send(dir_in[i], dir_exp[i], dir_inx[i], 1'b1);
    repeat (4) step(1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, acc);

    // Backpressure: out_ready low for cycles 2..7 of this phase.
    idx = 0; t = 0; first_low = 1'b0;
    while (idx < 8 && t < 40) begin
      step(1'b1, bp_in[idx], !(t >= 2 && t <= 7), bp_exp[idx], 1'b0, 1'b0, acc);
      if (!in_ready && !first_low) begin
        first_low = 1'b1;
        check("bp_fill_count", 32'(idx), 32'd3);
      end
      if (acc) idx++;
      t++;
    end
    check("bp_all_accepted", 32'(idx), 32'd8);
    check("bp_in_ready_dropped", {31'd0, first_low}, 32'd1);
    repeat (5) step(1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, acc);

    // Throughput: 100 random samples, one per cycle.
    for (int i = 0; i < 100; i++) begin
      x = $urandom;
      r = ref_conv(x);
      step(1'b1, x, 1'b1, r[31:0], r[32], 1'b1, acc);
      check("tp_accept", {31'd0, acc}, 32'd1);
    end
    repeat (5) step(1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, acc);

    // Reset with two samples in flight.
    step(1'b1, 32'h1234_5678, 1'b1, 32'd0, 1'b0, 1'b0, acc);
    step(1'b1, 32'hEDCB_A987, 1'b1, 32'd0, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    mon_en = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0;
    sb.delete();
    head_seen = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_data", out_data, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    mon_en = 1'b1;
    repeat (6) step(1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, acc);

    // One sample after the flush still converts correctly.
    send(32'hF000_0000, 32'hBF80_0000, 1'b0, 1'b1);

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      step(1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
      w++;
    end
    check("drain_remaining", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
